// File: rtl/frame_line_sequencer_if.sv
// Bus between the line timing logic / frame controller and the line-frame
// sequencer. The sequencer sits on the slave modport.
// Strobe semantics: newLine has no ready. Each cycle it is high while the
// sequencer is ACTIVE counts as exactly one line. It is ignored in IDLE and in
// DONE. endFrame is a one-cycle pulse with no acknowledge.
interface frame_line_sequencer_if #(
  parameter int LINE_W      = 5,
  parameter int FRAME_CNT_W = 8
) ();
  logic                   enb;
  logic                   newLine;
  logic                   mode_cont;
  logic [LINE_W-1:0]      cfg_lines;
  logic [LINE_W-1:0]      line_idx;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   endFrame;
  logic                   frame_active;
  logic                   done;
  logic [1:0]             state_dbg;

  modport master (
    output enb, newLine, mode_cont, cfg_lines,
    input  line_idx, frame_cnt, endFrame, frame_active, done, state_dbg
  );

  modport slave (
    input  enb, newLine, mode_cont, cfg_lines,
    output line_idx, frame_cnt, endFrame, frame_active, done, state_dbg
  );
endinterface

// File: rtl/frame_line_sequencer.sv
// Line/frame sequencer: counts newLine strobes against a frame height that is
// latched when the block is enabled. It pulses endFrame at each frame boundary
// and keeps a wrapping count of completed frames. In continuous mode it runs
// frame after frame. In single-shot mode it stops in DONE after one frame.
module frame_line_sequencer #(
  parameter int LINE_W      = 5,
  parameter int FRAME_LINES = 24,
  parameter int FRAME_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  frame_line_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [LINE_W-1:0] DEF_LINES = LINE_W'(FRAME_LINES);

  state_t                 state, state_n;
  logic [LINE_W-1:0]      n_lat, n_lat_n;
  logic [LINE_W-1:0]      line_q, line_n;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_n;
  logic                   end_n;
  logic                   end_q, active_q, done_q;

  // Next-state and next-counter logic. A low enable overrides everything,
  // including a terminal newLine in the same cycle.
  always_comb begin
    state_n = state;
    n_lat_n = n_lat;
    line_n  = line_q;
    cnt_n   = cnt_q;
    end_n   = 1'b0;
    if (!bus.enb) begin
      state_n = IDLE;
      line_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          // The frame height is captured here only. A newLine in this cycle
          // does not count as a line.
          n_lat_n = (bus.cfg_lines == '0) ? DEF_LINES : bus.cfg_lines;
          state_n = ACTIVE;
        end
        ACTIVE: begin
          if (bus.newLine) begin
            if (line_q == n_lat - LINE_W'(1)) begin
              line_n = '0;
              end_n  = 1'b1;
              cnt_n  = cnt_q + FRAME_CNT_W'(1);
              if (!bus.mode_cont) state_n = DONE;
            end else begin
              line_n = line_q + LINE_W'(1);
            end
          end
        end
        DONE: begin
          line_n = '0;
        end
        default: begin
          state_n = IDLE;
          line_n  = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State and output registers. The status flags are derived from the next
  // state, so each flag changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_lat    <= DEF_LINES;
      line_q   <= '0;
      cnt_q    <= '0;
      end_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      n_lat    <= n_lat_n;
      line_q   <= line_n;
      cnt_q    <= cnt_n;
      end_q    <= end_n;
      active_q <= (state_n == ACTIVE);
      done_q   <= (state_n == DONE);
    end
  end

  assign bus.line_idx     = line_q;
  assign bus.frame_cnt    = cnt_q;
  assign bus.endFrame     = end_q;
  assign bus.frame_active = active_q;
  assign bus.done         = done_q;
  assign bus.state_dbg    = state;

endmodule
